// File: rtl/conv_window_feeder_pkg.sv
// Shared constants and encodings for the 3x3 convolution window feeder.
// The selecK_I encodings are also used by the convolver.
package conv_window_feeder_pkg;

  localparam int BIT_LEN   = 8;
  localparam int IMG_WIDTH = 640;
  localparam int ADDR_LEN  = 10;
  localparam int M_LEN     = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KLOAD  = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  localparam logic KSEL = 1'b0;
  localparam logic ISEL = 1'b1;

endpackage

// File: rtl/conv_window_feeder_if.sv
// Pixel/kernel stream in, column pushes out to the convolver.
// The master side drives the i_* signals; the feeder is the slave.
interface conv_window_feeder_if #(
  parameter int BIT_LEN  = 8,
  parameter int ADDR_LEN = 10
);

  logic                i_start;
  logic                i_kernel_load;
  logic [ADDR_LEN-1:0] i_width;
  logic [ADDR_LEN-1:0] i_height;
  logic [BIT_LEN-1:0]  i_pixel;
  logic                i_pixel_valid;
  logic                o_pixel_ready;
  logic [BIT_LEN-1:0]  o_dato0;
  logic [BIT_LEN-1:0]  o_dato1;
  logic [BIT_LEN-1:0]  o_dato2;
  logic                o_selecK_I;
  logic                o_valid;
  logic                o_result_valid;
  logic                o_busy;
  logic                o_frame_done;

  modport master (
    output i_start, i_kernel_load, i_width, i_height, i_pixel, i_pixel_valid,
    input  o_pixel_ready, o_dato0, o_dato1, o_dato2, o_selecK_I, o_valid,
           o_result_valid, o_busy, o_frame_done
  );

  modport slave (
    input  i_start, i_kernel_load, i_width, i_height, i_pixel, i_pixel_valid,
    output o_pixel_ready, o_dato0, o_dato1, o_dato2, o_selecK_I, o_valid,
           o_result_valid, o_busy, o_frame_done
  );

endinterface

// File: rtl/conv_window_feeder_line_buffer.sv
// Two image rows held side by side: both rows share one column address,
// read asynchronously and written together on the clock edge.
// Contents are deliberately not reset; every frame refills them in rows 0 and 1.
module conv_line_buffer #(
  parameter int BIT_LEN  = 8,
  parameter int DEPTH    = 640,
  parameter int ADDR_LEN = 10
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic [BIT_LEN-1:0]  wdata0,
  input  logic [BIT_LEN-1:0]  wdata1,
  output logic [BIT_LEN-1:0]  rdata0,
  output logic [BIT_LEN-1:0]  rdata1
);

  logic [BIT_LEN-1:0] row0 [DEPTH];
  logic [BIT_LEN-1:0] row1 [DEPTH];

  assign rdata0 = row0[addr];
  assign rdata1 = row1[addr];

  // Shift the column up by one row: older row takes the newer one, newer takes the pixel.
  always_ff @(posedge clk) begin
    if (we) begin
      row0[addr] <= wdata0;
      row1[addr] <= wdata1;
    end
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Feeds 3-pixel vertical columns (or kernel columns) to the 3x3 convolver.
//
// state  | meaning
// IDLE   | waiting for i_kernel_load or a valid i_start, not ready
// KLOAD  | accepting 9 kernel bytes, one push per 3 bytes
// STREAM | accepting raster pixels, pushing columns from row 2 on
// FLUSH  | one stall cycle; a zero column is pushed to close the row
module conv_window_feeder #(
  parameter int BIT_LEN   = conv_window_feeder_pkg::BIT_LEN,
  parameter int IMG_WIDTH = conv_window_feeder_pkg::IMG_WIDTH,
  parameter int ADDR_LEN  = conv_window_feeder_pkg::ADDR_LEN
) (
  input logic                 CLK100MHZ,
  input logic                 i_reset,
  conv_window_feeder_if.slave bus
);

  import conv_window_feeder_pkg::*;

  localparam logic [1:0]          LAST_K = 2'(M_LEN - 1);
  localparam logic [ADDR_LEN-1:0] MIN_DIM = ADDR_LEN'(3);
  localparam logic [ADDR_LEN:0]   MAX_W   = (ADDR_LEN+1)'(IMG_WIDTH);

  state_t state, state_nxt;

  logic [ADDR_LEN-1:0] col, row, w_lat, h_lat;
  logic [1:0]          kbyte, kcol;
  logic [BIT_LEN-1:0]  kb0, kb1;
  logic [BIT_LEN-1:0]  lb_rd0, lb_rd1;

  logic accept, last_col, last_row, row_ge2, start_ok, lb_we;

  logic [BIT_LEN-1:0] d0_q, d1_q, d2_q;
  logic               sel_q, valid_q, res_tag_q, res_q, done_pend_q, done_q;

  logic [BIT_LEN-1:0] d0_nxt, d1_nxt, d2_nxt;
  logic               sel_nxt, push_nxt, res_nxt, done_nxt;

  assign bus.o_pixel_ready  = (state == KLOAD) || (state == STREAM);
  assign bus.o_busy         = (state != IDLE);
  assign bus.o_dato0        = d0_q;
  assign bus.o_dato1        = d1_q;
  assign bus.o_dato2        = d2_q;
  assign bus.o_selecK_I     = sel_q;
  assign bus.o_valid        = valid_q;
  assign bus.o_result_valid = res_q;
  assign bus.o_frame_done   = done_q;

  assign accept   = bus.i_pixel_valid && bus.o_pixel_ready;
  assign last_col = (col == w_lat - 1'b1);
  assign last_row = (row == h_lat - 1'b1);
  assign row_ge2  = (row >= ADDR_LEN'(2));
  assign start_ok = bus.i_start && (bus.i_width >= MIN_DIM) &&
                    ({1'b0, bus.i_width} <= MAX_W) && (bus.i_height >= MIN_DIM);
  assign lb_we    = (state == STREAM) && accept;

  conv_line_buffer #(
    .BIT_LEN (BIT_LEN),
    .DEPTH   (IMG_WIDTH),
    .ADDR_LEN(ADDR_LEN)
  ) u_lb (
    .clk   (CLK100MHZ),
    .we    (lb_we),
    .addr  (col),
    .wdata0(lb_rd1),
    .wdata1(bus.i_pixel),
    .rdata0(lb_rd0),
    .rdata1(lb_rd1)
  );

  // State register.
  always_ff @(posedge CLK100MHZ or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and the values the output registers take on the next edge.
  always_comb begin
    state_nxt = state;
    push_nxt  = 1'b0;
    res_nxt   = 1'b0;
    done_nxt  = 1'b0;
    sel_nxt   = sel_q;
    d0_nxt    = d0_q;
    d1_nxt    = d1_q;
    d2_nxt    = d2_q;
    case (state)
      IDLE: begin
        // Kernel load has priority over a simultaneous start.
        if (bus.i_kernel_load) state_nxt = KLOAD;
        else if (start_ok)     state_nxt = STREAM;
      end
      KLOAD: begin
        if (accept && kbyte == LAST_K) begin
          push_nxt = 1'b1;
          sel_nxt  = KSEL;
          d0_nxt   = kb0;
          d1_nxt   = kb1;
          d2_nxt   = bus.i_pixel;
          if (kcol == LAST_K) state_nxt = IDLE;
        end
      end
      STREAM: begin
        if (accept) begin
          if (row_ge2) begin
            push_nxt = 1'b1;
            sel_nxt  = ISEL;
            d0_nxt   = lb_rd0;
            d1_nxt   = lb_rd1;
            d2_nxt   = bus.i_pixel;
            // Columns 0..2 only shift the previous row's flush zeros out.
            res_nxt  = (col >= ADDR_LEN'(3));
            if (last_col) state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        push_nxt  = 1'b1;
        sel_nxt   = ISEL;
        d0_nxt    = '0;
        d1_nxt    = '0;
        d2_nxt    = '0;
        res_nxt   = 1'b1;
        done_nxt  = last_row;
        state_nxt = last_row ? IDLE : STREAM;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs; result and frame-done trail their push by one cycle.
  always_ff @(posedge CLK100MHZ or posedge i_reset) begin
    if (i_reset) begin
      d0_q        <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      sel_q       <= 1'b0;
      valid_q     <= 1'b0;
      res_tag_q   <= 1'b0;
      res_q       <= 1'b0;
      done_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      d0_q        <= d0_nxt;
      d1_q        <= d1_nxt;
      d2_q        <= d2_nxt;
      sel_q       <= sel_nxt;
      valid_q     <= push_nxt;
      res_tag_q   <= res_nxt;
      res_q       <= res_tag_q;
      done_pend_q <= done_nxt;
      done_q      <= done_pend_q;
    end
  end

  // Column/row counters, latched frame size and kernel byte packing.
  always_ff @(posedge CLK100MHZ or posedge i_reset) begin
    if (i_reset) begin
      col   <= '0;
      row   <= '0;
      w_lat <= '0;
      h_lat <= '0;
      kbyte <= '0;
      kcol  <= '0;
      kb0   <= '0;
      kb1   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_kernel_load) begin
            kbyte <= '0;
            kcol  <= '0;
          end else if (start_ok) begin
            w_lat <= bus.i_width;
            h_lat <= bus.i_height;
            col   <= '0;
            row   <= '0;
          end
        end
        KLOAD: begin
          if (accept) begin
            if (kbyte == 2'd0) kb0 <= bus.i_pixel;
            if (kbyte == 2'd1) kb1 <= bus.i_pixel;
            if (kbyte == LAST_K) begin
              kbyte <= '0;
              kcol  <= kcol + 2'd1;
            end else begin
              kbyte <= kbyte + 2'd1;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            if (last_col) begin
              col <= '0;
              // Rows from 2 on advance after the flush instead.
              if (!row_ge2) row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (!last_row) row <= row + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
